factor_checker: RTL and testbench

//   Consumer end of the factoriser result interface: takes the composite n and the reported factor

---
 rtl/factor_pkg.sv | 19 +
 rtl/factor_checker_div_step.sv | 21 ++
 rtl/factor_checker.sv | 144 ++++++++++++++
 tb/tb_factor_checker.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/factor_pkg.sv
// Shared widths and FSM encoding for the factor checker.
package factor_pkg;

    localparam int unsigned N_W_DEF = 64;
    localparam int unsigned P_W_DEF = 32;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CHECK = 2'd1;
    localparam logic [1:0] ST_DIV   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        CHECK = ST_CHECK,
        DIV   = ST_DIV,
        DONE  = ST_DONE
    } state_t;

endpackage

// File: rtl/factor_checker_div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the divisor if it fits.
module factor_checker_div_step #(
    parameter int unsigned P_W = 32
) (
    input  logic [P_W-1:0] partial,
    input  logic           n_bit,
    input  logic [P_W-1:0] divisor,
    output logic [P_W-1:0] partial_next,
    output logic           q_bit
);

    logic [P_W:0] shifted;

    // partial < divisor on entry, so the shifted value fits in P_W+1 bits and the result in P_W.
    always_comb begin
        shifted      = {partial, n_bit};
        q_bit        = (shifted >= {1'b0, divisor});
        partial_next = q_bit ? P_W'(shifted - {1'b0, divisor}) : shifted[P_W-1:0];
    end

endmodule

// File: rtl/factor_checker.sv
// Verifies that prime1 divides n non-trivially via sequential restoring division.
// Optional macro FACTOR_CHECKER_EARLY_EXIT_EN skips the leading zero bits of n.
module factor_checker
    import factor_pkg::*;
#(
    parameter int unsigned N_W = N_W_DEF,
    parameter int unsigned P_W = P_W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N_W-1:0] n,
    input  logic [P_W-1:0] prime1,
    output logic           busy,
    output logic           done,
    output logic           valid_factor,
    output logic           div_by_zero,
    output logic [N_W-1:0] cofactor,
    output logic [P_W-1:0] remainder
);

    localparam int unsigned CNT_W = $clog2(N_W + 1);

    state_t state_q, state_d;

    logic [N_W-1:0]   n_q;
    logic [N_W-1:0]   nsh_q;
    logic [P_W-1:0]   p_q;
    logic [P_W-1:0]   r_q;
    logic [N_W-1:0]   q_q;
    logic [CNT_W-1:0] cnt_q;

    logic [P_W-1:0]   r_next;
    logic             q_bit;
    logic [N_W-1:0]   q_next;
    logic             valid_next;

`ifdef FACTOR_CHECKER_EARLY_EXIT_EN
    function automatic logic [CNT_W-1:0] msb_index(input logic [N_W-1:0] v);
        logic [CNT_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_W; i++) begin
            if (v[i]) idx = CNT_W'(i);
        end
        return idx;
    endfunction

    logic [CNT_W-1:0] msb_k;
    assign msb_k = msb_index(n_q);
`endif

    factor_checker_div_step #(
        .P_W (P_W)
    ) u_div_step (
        .partial      (r_q),
        .n_bit        (nsh_q[N_W-1]),
        .divisor      (p_q),
        .partial_next (r_next),
        .q_bit        (q_bit)
    );

    always_comb begin
        q_next     = {q_q[N_W-2:0], q_bit};
        // 1 and n itself are trivial factors; p is zero-extended for the compare.
        valid_next = (r_next == '0) && (p_q > P_W'(1)) &&
                     ({{(N_W-P_W){1'b0}}, p_q} < n_q);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = CHECK;
            CHECK:   state_d = (p_q == '0) ? DONE : DIV;
            DIV:     if (cnt_q == CNT_W'(1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            n_q          <= '0;
            nsh_q        <= '0;
            p_q          <= '0;
            r_q          <= '0;
            q_q          <= '0;
            cnt_q        <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            valid_factor <= 1'b0;
            div_by_zero  <= 1'b0;
            cofactor     <= '0;
            remainder    <= '0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        n_q          <= n;
                        p_q          <= prime1;
                        busy         <= 1'b1;
                        valid_factor <= 1'b0;
                        div_by_zero  <= 1'b0;
                        cofactor     <= '0;
                        remainder    <= '0;
                    end
                end
                CHECK: begin
                    r_q <= '0;
                    q_q <= '0;
`ifdef FACTOR_CHECKER_EARLY_EXIT_EN
                    nsh_q <= n_q << (CNT_W'(N_W - 1) - msb_k);
                    cnt_q <= msb_k + CNT_W'(1);
`else
                    nsh_q <= n_q;
                    cnt_q <= CNT_W'(N_W);
`endif
                    if (p_q == '0) begin
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        div_by_zero <= 1'b1;
                    end
                end
                DIV: begin
                    r_q   <= r_next;
                    q_q   <= q_next;
                    nsh_q <= nsh_q << 1;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        busy         <= 1'b0;
                        done         <= 1'b1;
                        cofactor     <= q_next;
                        remainder    <= r_next;
                        valid_factor <= valid_next;
                    end
                end
                DONE: done <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_factor_checker.sv
// Directed bench for factor_checker: results, latency, busy/done timing, reset abort.
module tb_factor_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] n;
    logic [31:0] prime1;
    logic        busy;
    logic        done;
    logic        valid_factor;
    logic        div_by_zero;
    logic [63:0] cofactor;
    logic [31:0] remainder;

    int compared   = 0;
    int mismatched = 0;
    int edges      = 0;

    factor_checker dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .n            (n),
        .prime1       (prime1),
        .busy         (busy),
        .done         (done),
        .valid_factor (valid_factor),
        .div_by_zero  (div_by_zero),
        .cofactor     (cofactor),
        .remainder    (remainder)
    );

    always #5 clk = ~clk;

    function automatic int exp_lat(input logic [63:0] nv, input logic [31:0] pv);
        int k;
        if (pv == 0) return 2;
`ifdef FACTOR_CHECKER_EARLY_EXIT_EN
        k = 0;
        for (int i = 0; i < 64; i++) if (nv[i]) k = i;
        return k + 3;
`else
        k = 0;
        if (nv == 0) k = 0;
        return 66;
`endif
    endfunction

    // Starts a check, scrambles the inputs after acceptance, and waits for done.
    // lat is -1 if done never arrives; busy_run clears if busy dropped before done.
    task automatic do_check(input logic [63:0] nv, input logic [31:0] pv, input bit poke,
                            output int lat, output bit busy_run);
        @(negedge clk);
        n = nv; prime1 = pv; start = 1'b1;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        start = 1'b0; n = 64'h0123_4567_89AB_CDEF; prime1 = 32'd3;
        busy_run = 1'b1;
        lat = -1;
        for (int i = 0; i < 200; i++) begin
            if (done) begin
                lat = edges;
                break;
            end
            if (!busy) busy_run = 1'b0;
            if (poke && i == 1) begin start = 1'b1; n = 64'd100; prime1 = 32'd10; end
            if (poke && i == 2) start = 1'b0;
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b1; n = 64'd485; prime1 = 32'd5;
        repeat (3) @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        rst = 1'b0;
        compared++;
        if ({busy, done, valid_factor, div_by_zero} !== 4'b0000) begin
            mismatched++;
            $display("FAIL reset_flags: got %b want 0000", {busy, done, valid_factor, div_by_zero});
        end
        compared++;
        if (cofactor !== 64'd0 || remainder !== 32'd0) begin
            mismatched++;
            $display("FAIL reset_data: got cof=%0d rem=%0d want 0/0", cofactor, remainder);
        end
    endtask

    task automatic test_divisible;
        int lat; bit br;
        do_check(64'd485, 32'd5, 1'b0, lat, br);
        compared++;
        if (lat !== exp_lat(64'd485, 32'd5)) begin
            mismatched++;
            $display("FAIL div5_latency: got %0d want %0d", lat, exp_lat(64'd485, 32'd5));
        end
        compared++;
        if (br !== 1'b1 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL div5_busy: run=%b at_done=%b want 1/0", br, busy);
        end
        compared++;
        if (cofactor !== 64'd97 || remainder !== 32'd0 || valid_factor !== 1'b1 ||
            div_by_zero !== 1'b0) begin
            mismatched++;
            $display("FAIL div5_result: got cof=%0d rem=%0d vf=%b dz=%b want 97/0/1/0",
                     cofactor, remainder, valid_factor, div_by_zero);
        end
        @(negedge clk);
        compared++;
        if (done !== 1'b0 || cofactor !== 64'd97 || valid_factor !== 1'b1) begin
            mismatched++;
            $display("FAIL div5_hold: got done=%b cof=%0d vf=%b want 0/97/1",
                     done, cofactor, valid_factor);
        end
    endtask

    task automatic test_remainder;
        int lat; bit br;
        do_check(64'd485, 32'd7, 1'b0, lat, br);
        compared++;
        if (lat !== exp_lat(64'd485, 32'd7) || cofactor !== 64'd69 || remainder !== 32'd2 ||
            valid_factor !== 1'b0 || div_by_zero !== 1'b0) begin
            mismatched++;
            $display("FAIL div7: got lat=%0d cof=%0d rem=%0d vf=%b dz=%b want %0d/69/2/0/0",
                     lat, cofactor, remainder, valid_factor, div_by_zero,
                     exp_lat(64'd485, 32'd7));
        end
    endtask

    task automatic test_div_by_zero;
        int lat; bit br;
        do_check(64'd485, 32'd0, 1'b0, lat, br);
        compared++;
        if (lat !== 2) begin
            mismatched++;
            $display("FAIL dz_latency: got %0d want 2", lat);
        end
        compared++;
        if (div_by_zero !== 1'b1 || cofactor !== 64'd0 || remainder !== 32'd0 ||
            valid_factor !== 1'b0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL dz_result: got dz=%b cof=%0d rem=%0d vf=%b busy=%b want 1/0/0/0/0",
                     div_by_zero, cofactor, remainder, valid_factor, busy);
        end
    endtask

    task automatic test_trivial;
        int lat; bit br;
        do_check(64'd485, 32'd1, 1'b0, lat, br);
        compared++;
        if (cofactor !== 64'd485 || remainder !== 32'd0 || valid_factor !== 1'b0) begin
            mismatched++;
            $display("FAIL triv_one: got cof=%0d rem=%0d vf=%b want 485/0/0",
                     cofactor, remainder, valid_factor);
        end
        do_check(64'd485, 32'd485, 1'b0, lat, br);
        compared++;
        if (cofactor !== 64'd1 || remainder !== 32'd0 || valid_factor !== 1'b0) begin
            mismatched++;
            $display("FAIL triv_self: got cof=%0d rem=%0d vf=%b want 1/0/0",
                     cofactor, remainder, valid_factor);
        end
        do_check(64'd0, 32'd3, 1'b0, lat, br);
        compared++;
        if (lat !== exp_lat(64'd0, 32'd3) || cofactor !== 64'd0 || remainder !== 32'd0 ||
            valid_factor !== 1'b0) begin
            mismatched++;
            $display("FAIL zero_n: got lat=%0d cof=%0d rem=%0d vf=%b want %0d/0/0/0",
                     lat, cofactor, remainder, valid_factor, exp_lat(64'd0, 32'd3));
        end
    endtask

    task automatic test_max;
        int lat; bit br;
        do_check(64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat, br);
        compared++;
        if (lat !== exp_lat(64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF) ||
            cofactor !== 64'h1_0000_0001 || remainder !== 32'd0 || valid_factor !== 1'b1) begin
            mismatched++;
            $display("FAIL max: got lat=%0d cof=%h rem=%h vf=%b want 66-or-early/100000001/0/1",
                     lat, cofactor, remainder, valid_factor);
        end
        do_check(64'd1000, 32'd1000000, 1'b0, lat, br);
        compared++;
        if (cofactor !== 64'd0 || remainder !== 32'd1000 || valid_factor !== 1'b0) begin
            mismatched++;
            $display("FAIL p_gt_n: got cof=%0d rem=%0d vf=%b want 0/1000/0",
                     cofactor, remainder, valid_factor);
        end
    endtask

    task automatic test_reset_abort;
        int lat; bit br; int dones;
        @(negedge clk);
        n = 64'd485; prime1 = 32'd5; start = 1'b1;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        start = 1'b0;
        while (edges < 19) begin
            @(posedge clk); edges++; @(negedge clk);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 80; i++) begin
            if (done) dones++;
            @(negedge clk);
        end
        compared++;
        if (dones !== 0 || busy !== 1'b0 || cofactor !== 64'd0 || valid_factor !== 1'b0 ||
            remainder !== 32'd0 || div_by_zero !== 1'b0) begin
            mismatched++;
            $display("FAIL abort: got dones=%0d busy=%b cof=%0d vf=%b want 0/0/0/0",
                     dones, busy, cofactor, valid_factor);
        end
        do_check(64'd485, 32'd97, 1'b1, lat, br);
        compared++;
        if (lat !== exp_lat(64'd485, 32'd97) || br !== 1'b1 || cofactor !== 64'd5 ||
            remainder !== 32'd0 || valid_factor !== 1'b1) begin
            mismatched++;
            $display("FAIL after_abort: got lat=%0d busy=%b cof=%0d rem=%0d vf=%b want %0d/1/5/0/1",
                     lat, br, cofactor, remainder, valid_factor, exp_lat(64'd485, 32'd97));
        end
    endtask

    task automatic test_back_to_back;
        int lat; bit br;
        do_check(64'd221, 32'd13, 1'b0, lat, br);
        compared++;
        if (cofactor !== 64'd17 || remainder !== 32'd0 || valid_factor !== 1'b1) begin
            mismatched++;
            $display("FAIL b2b_first: got cof=%0d rem=%0d vf=%b want 17/0/1",
                     cofactor, remainder, valid_factor);
        end
        do_check(64'd1_000_003, 32'd10, 1'b0, lat, br);
        compared++;
        if (cofactor !== 64'd100_000 || remainder !== 32'd3 || valid_factor !== 1'b0) begin
            mismatched++;
            $display("FAIL b2b_second: got cof=%0d rem=%0d vf=%b want 100000/3/0",
                     cofactor, remainder, valid_factor);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; n = '0; prime1 = '0;
        test_reset();
        test_divisible();
        test_remainder();
        test_div_by_zero();
        test_trivial();
        test_max();
        test_reset_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
